// File: rtl/pmesh_l2_pkg.sv
// pmesh_l2_pkg: shared L2<->L1 message definitions.
//   - field widths for type/tag/source/data
//   - 8-bit message type codes used on msg2 (L2->L1) and msg3 (L1->L2)
//   - FSM state enum for the L1 msg2 receiver
//   - msg2 payload struct and small decode helpers
package pmesh_l2_pkg;

  localparam int MSG_TYPE_W = 8;
  localparam int MSG_TAG_W  = 26;
  localparam int MSG_SRC_W  = 6;
  localparam int MSG_DATA_W = 64;

  localparam logic [MSG_TYPE_W-1:0] LOAD_FWD     = 8'd16;
  localparam logic [MSG_TYPE_W-1:0] STORE_FWD    = 8'd17;
  localparam logic [MSG_TYPE_W-1:0] INV_FWD      = 8'd18;
  localparam logic [MSG_TYPE_W-1:0] LOAD_FWDACK  = 8'd22;
  localparam logic [MSG_TYPE_W-1:0] STORE_FWDACK = 8'd23;
  localparam logic [MSG_TYPE_W-1:0] INV_FWDACK   = 8'd24;
  localparam logic [MSG_TYPE_W-1:0] DATA_ACK     = 8'd27;
  localparam logic [MSG_TYPE_W-1:0] NODATA_ACK   = 8'd28;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_MSG3 = 2'd1,
    SEND_CORE = 2'd2
  } l1_rx_state_e;

  typedef struct packed {
    logic [MSG_TYPE_W-1:0] mtype;
    logic [MSG_TAG_W-1:0]  tag;
    logic [MSG_DATA_W-1:0] data;
  } msg2_t;

  // Forwarded requests from L2 that the L1 must acknowledge on msg3.
  function automatic logic is_fwd(input logic [MSG_TYPE_W-1:0] t);
    return (t == INV_FWD) || (t == STORE_FWD) || (t == LOAD_FWD);
  endfunction

  // Fills/acks that go straight to the core.
  function automatic logic is_core_ack(input logic [MSG_TYPE_W-1:0] t);
    return (t == DATA_ACK) || (t == NODATA_ACK);
  endfunction

  // Ack code returned for a forwarded request; 0 for anything else.
  function automatic logic [MSG_TYPE_W-1:0] fwd_ack_type(input logic [MSG_TYPE_W-1:0] t);
    logic [MSG_TYPE_W-1:0] r;
    r = '0;
    if (t == INV_FWD)   r = INV_FWDACK;
    if (t == STORE_FWD) r = STORE_FWDACK;
    if (t == LOAD_FWD)  r = LOAD_FWDACK;
    return r;
  endfunction

endpackage

// File: rtl/pmesh_msg_fifo.sv
// pmesh_msg_fifo: small synchronous FIFO with occupancy count.
//   clk, rst      : clock, async active-high reset (pointers/count only)
//   push_i, din_i : write request / data (ignored when full)
//   pop_i         : read request (ignored when empty)
//   dout_o        : head entry (valid while empty_o is low)
//   count_o       : current occupancy, 0..DEPTH
//   empty_o       : occupancy is zero
module pmesh_msg_fifo #(
  parameter int WIDTH = 98,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (cnt_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i && (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // explicit wrap keeps the pointers correct for non-power-of-two depths too
    if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // storage needs no reset: an entry is only read after it has been written
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pmesh_l1_msg2_rx.sv
// pmesh_l1_msg2_rx: L1 receiver for L2->L1 (msg2) messages.
// Buffers msg2 in a small FIFO, then either answers forwarded requests with an
// ack on msg3 or hands fills/acks to the core. Unknown types are dropped.
//   clk, rst                  : clock, async active-high reset
//   msg2_valid/ready/type/tag/data       : incoming L2 message
//   msg3_valid/ready/type/tag/source/data: outgoing ack to L2
//   core_resp_valid/ready/type/data      : fill/ack to the core
//   busy                      : FIFO non-empty or FSM not IDLE
//   err_cnt                   : saturating dropped-message counter, only when
//                               PMESH_L1_MSG2_RX_ERRCNT_EN is defined
// Latency: a message transferred in cycle k is presented in cycle k+2
// (pop at the end of k+1); steady-state rate is one message per 2 cycles.
module pmesh_l1_msg2_rx
  import pmesh_l2_pkg::*;
#(
  parameter logic [MSG_SRC_W-1:0] NODE_ID    = 6'd0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  msg2_valid,
  input  logic [MSG_TYPE_W-1:0] msg2_type,
  input  logic [MSG_TAG_W-1:0]  msg2_tag,
  input  logic [MSG_DATA_W-1:0] msg2_data,
  output logic                  msg2_ready,
  output logic                  msg3_valid,
  output logic [MSG_TYPE_W-1:0] msg3_type,
  output logic [MSG_TAG_W-1:0]  msg3_tag,
  output logic [MSG_SRC_W-1:0]  msg3_source,
  output logic [MSG_DATA_W-1:0] msg3_data,
  input  logic                  msg3_ready,
  output logic                  core_resp_valid,
  output logic [MSG_TYPE_W-1:0] core_resp_type,
  output logic [MSG_DATA_W-1:0] core_resp_data,
  input  logic                  core_resp_ready,
  output logic                  busy
`ifdef PMESH_L1_MSG2_RX_ERRCNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  msg2_t            push_msg, head;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_empty, push, pop;

  l1_rx_state_e          state_q, state_d;
  logic [MSG_TYPE_W-1:0] cur_type_q, cur_type_d;
  logic [MSG_TAG_W-1:0]  cur_tag_q, cur_tag_d;
  logic [MSG_DATA_W-1:0] cur_data_q, cur_data_d;
  logic [MSG_TYPE_W-1:0] ack_type_q, ack_type_d;
  logic [MSG_SRC_W-1:0]  src_q, src_d;

  assign msg2_ready = (fifo_cnt < CNT_W'(FIFO_DEPTH));
  assign push       = msg2_valid && msg2_ready;
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign push_msg   = '{mtype: msg2_type, tag: msg2_tag, data: msg2_data};

  pmesh_msg_fifo #(
    .WIDTH ($bits(msg2_t)),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_msg),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cur_type_d = cur_type_q;
    cur_tag_d  = cur_tag_q;
    cur_data_d = cur_data_q;
    ack_type_d = ack_type_q;
    src_d      = src_q;
    case (state_q)
      IDLE: begin
        // payload registers are only reloaded for messages that will be
        // presented, so a dropped message never disturbs the outputs
        if (pop) begin
          if (is_fwd(head.mtype)) begin
            state_d    = SEND_MSG3;
            cur_type_d = head.mtype;
            cur_tag_d  = head.tag;
            cur_data_d = head.data;
            ack_type_d = fwd_ack_type(head.mtype);
            src_d      = NODE_ID;
          end else if (is_core_ack(head.mtype)) begin
            state_d    = SEND_CORE;
            cur_type_d = head.mtype;
            cur_tag_d  = head.tag;
            cur_data_d = head.data;
          end
        end
      end
      SEND_MSG3: if (msg3_ready)      state_d = IDLE;
      SEND_CORE: if (core_resp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_type_q <= '0;
      cur_tag_q  <= '0;
      cur_data_q <= '0;
      ack_type_q <= '0;
      src_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_type_q <= cur_type_d;
      cur_tag_q  <= cur_tag_d;
      cur_data_q <= cur_data_d;
      ack_type_q <= ack_type_d;
      src_q      <= src_d;
    end
  end

  // valids decode the state register, so they are registered and can never
  // be high together
  assign msg3_valid      = (state_q == SEND_MSG3);
  assign msg3_type       = ack_type_q;
  assign msg3_tag        = cur_tag_q;
  assign msg3_source     = src_q;
  assign msg3_data       = cur_data_q;
  assign core_resp_valid = (state_q == SEND_CORE);
  assign core_resp_type  = cur_type_q;
  assign core_resp_data  = cur_data_q;
  assign busy            = !fifo_empty || (state_q != IDLE);

`ifdef PMESH_L1_MSG2_RX_ERRCNT_EN
  logic       drop;
  logic [7:0] err_cnt_q;

  assign drop = pop && !is_fwd(head.mtype) && !is_core_ack(head.mtype);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              err_cnt_q <= '0;
    else if (drop && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pmesh_l1_msg2_rx.sv
module tb_pmesh_l1_msg2_rx;
  import pmesh_l2_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg2_valid;
  logic [7:0]  msg2_type;
  logic [25:0] msg2_tag;
  logic [63:0] msg2_data;
  logic        msg2_ready;
  logic        msg3_valid;
  logic [7:0]  msg3_type;
  logic [25:0] msg3_tag;
  logic [5:0]  msg3_source;
  logic [63:0] msg3_data;
  logic        msg3_ready;
  logic        core_resp_valid;
  logic [7:0]  core_resp_type;
  logic [63:0] core_resp_data;
  logic        core_resp_ready;
  logic        busy;
`ifdef PMESH_L1_MSG2_RX_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int passed = 0;
  int total  = 0;

  pmesh_l1_msg2_rx #(.NODE_ID(6'd5), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .msg2_valid(msg2_valid), .msg2_type(msg2_type), .msg2_tag(msg2_tag),
    .msg2_data(msg2_data), .msg2_ready(msg2_ready),
    .msg3_valid(msg3_valid), .msg3_type(msg3_type), .msg3_tag(msg3_tag),
    .msg3_source(msg3_source), .msg3_data(msg3_data), .msg3_ready(msg3_ready),
    .core_resp_valid(core_resp_valid), .core_resp_type(core_resp_type),
    .core_resp_data(core_resp_data), .core_resp_ready(core_resp_ready),
    .busy(busy)
`ifdef PMESH_L1_MSG2_RX_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the edge on which the message was accepted.
  task automatic send(input logic [7:0] t, input logic [25:0] tg, input logic [63:0] d);
    int n;
    msg2_type  = t;
    msg2_tag   = tg;
    msg2_data  = d;
    msg2_valid = 1'b1;
    n = 0;
    while (!msg2_ready && n < 200) begin
      step();
      n++;
    end
    chk("send_ready", msg2_ready, 1);
    step();
    msg2_valid = 1'b0;
  endtask

  logic [7:0]  mon_type [10];
  logic [25:0] mon_tag  [10];
  logic [63:0] mon_data [10];
  int          mon_got;
  logic        mon_overlap;
  logic        saw;

  initial begin
    int n;
    rst = 1'b1;
    msg2_valid = 1'b0; msg2_type = '0; msg2_tag = '0; msg2_data = '0;
    msg3_ready = 1'b0; core_resp_ready = 1'b0;
    step(); step();

    // reset state
    chk("rst_msg3_valid", msg3_valid, 0);
    chk("rst_core_valid", core_resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_msg2_ready", msg2_ready, 1);
    chk("rst_msg3_type", msg3_type, 0);
    chk("rst_msg3_source", msg3_source, 0);
    chk("rst_core_data", core_resp_data, 0);
`ifdef PMESH_L1_MSG2_RX_ERRCNT_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    rst = 1'b0;
    step();

    // INV_FWD -> INV_FWDACK two cycles after transfer, one-cycle handshake
    msg3_ready = 1'b1;
    send(INV_FWD, 26'h0ABCDEF, 64'h1);
    chk("t1_valid_early", msg3_valid, 0);
    step();
    chk("t1_valid", msg3_valid, 1);
    chk("t1_type", msg3_type, INV_FWDACK);
    chk("t1_tag", msg3_tag, 26'h0ABCDEF);
    chk("t1_source", msg3_source, 6'd5);
    chk("t1_data", msg3_data, 64'h1);
    chk("t1_core_quiet", core_resp_valid, 0);
    step();
    chk("t1_valid_clr", msg3_valid, 0);
    chk("t1_busy", busy, 0);

    // DATA_ACK held while core stalls 5 cycles
    core_resp_ready = 1'b0;
    send(DATA_ACK, 26'h5, 64'hDEAD_BEEF);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid_hold", core_resp_valid, 1);
      chk("t2_data_hold", core_resp_data, 64'hDEAD_BEEF);
      chk("t2_type_hold", core_resp_type, DATA_ACK);
      if (i < 4) step();
    end
    core_resp_ready = 1'b1;
    step();
    chk("t2_valid_clr", core_resp_valid, 0);

    // backpressure fills FIFO_DEPTH=2 with one message in the FSM
    msg3_ready = 1'b0;
    send(INV_FWD, 26'h1, 64'd10);
    send(INV_FWD, 26'h2, 64'd20);
    send(INV_FWD, 26'h3, 64'd30);
    chk("t3_ready_low", msg2_ready, 0);
    chk("t3_head_valid", msg3_valid, 1);
    chk("t3_head_tag", msg3_tag, 26'h1);
    step(); step();
    chk("t3_ready_still_low", msg2_ready, 0);
    chk("t3_busy", busy, 1);
    msg3_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!msg3_valid && n < 20) begin
        step();
        n++;
      end
      chk("t3_ack_valid", msg3_valid, 1);
      chk("t3_ack_tag", msg3_tag, 26'(i + 1));
      chk("t3_ack_data", msg3_data, 64'((i + 1) * 10));
      chk("t3_ack_type", msg3_type, INV_FWDACK);
      step();
    end
    step();
    chk("t3_idle", busy, 0);

    // unknown type is dropped without output
    send(8'hEE, 26'h7, 64'h7);
    saw = 1'b0;
    repeat (4) begin
      step();
      saw = saw | msg3_valid | core_resp_valid;
    end
    chk("t4_no_output", saw, 0);
    chk("t4_busy", busy, 0);
`ifdef PMESH_L1_MSG2_RX_ERRCNT_EN
    chk("t4_err_cnt_1", err_cnt, 8'd1);
`endif
    saw = 1'b0;
    for (int i = 0; i < 300; i++) begin
      send(8'hEE, 26'(i), 64'(i));
      saw = saw | msg3_valid | core_resp_valid;
    end
    repeat (4) step();
    chk("t4_bulk_no_output", saw, 0);
    chk("t4_bulk_busy", busy, 0);
`ifdef PMESH_L1_MSG2_RX_ERRCNT_EN
    chk("t4_err_cnt_sat", err_cnt, 8'hFF);
`endif

    // reset during SEND_MSG3 with one entry queued
    msg3_ready = 1'b0;
    send(INV_FWD, 26'h11, 64'h11);
    step();
    chk("t5_pre_valid", msg3_valid, 1);
    send(INV_FWD, 26'h22, 64'h22);
    chk("t5_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_async_clr", msg3_valid, 0);
    chk("t5_async_data", msg3_data, 0);
    step();
    rst = 1'b0;
    step();
    chk("t5_valid", msg3_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_msg2_ready", msg2_ready, 1);
`ifdef PMESH_L1_MSG2_RX_ERRCNT_EN
    chk("t5_err_cnt", err_cnt, 0);
`endif
    msg3_ready = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      step();
      saw = saw | msg3_valid | core_resp_valid;
    end
    chk("t5_no_stale", saw, 0);

    // streaming alternating STORE_FWD / NODATA_ACK, both sinks ready
    msg3_ready = 1'b1;
    core_resp_ready = 1'b1;
    mon_got = 0;
    mon_overlap = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int w;
          msg2_type  = (i % 2 == 0) ? STORE_FWD : NODATA_ACK;
          msg2_tag   = 26'(100 + i);
          msg2_data  = 64'(i * 3 + 7);
          msg2_valid = 1'b1;
          w = 0;
          while (!msg2_ready && w < 50) begin
            step();
            w++;
          end
          step();
        end
        msg2_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 100 && mon_got < 10; c++) begin
          step();
          if (msg3_valid && core_resp_valid) mon_overlap = 1'b1;
          if (msg3_valid) begin
            mon_type[mon_got] = msg3_type;
            mon_tag[mon_got]  = msg3_tag;
            mon_data[mon_got] = msg3_data;
            mon_got++;
          end else if (core_resp_valid) begin
            mon_type[mon_got] = core_resp_type;
            mon_tag[mon_got]  = '0;
            mon_data[mon_got] = core_resp_data;
            mon_got++;
          end
        end
      end
    join
    chk("t6_count", 64'(mon_got), 64'd10);
    chk("t6_no_overlap", mon_overlap, 0);
    for (int i = 0; i < mon_got; i++) begin
      if (i % 2 == 0) begin
        chk("t6_type_msg3", mon_type[i], STORE_FWDACK);
        chk("t6_tag_msg3", mon_tag[i], 26'(100 + i));
      end else begin
        chk("t6_type_core", mon_type[i], NODATA_ACK);
      end
      chk("t6_data", mon_data[i], 64'(i * 3 + 7));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
